tmds_decoder: RTL and testbench
===============================

Name: tmds_decoder

Overview:
- Sink side of the TMDS link. Takes one 10-bit TMDS channel word per pixel clock from an external deserializer.
- Finds the word boundary by requesting bitslips until a run of control tokens is seen, then decodes 10b→8b pixel data and 2-bit control tokens.
- Used for HDMI loopback/capture testing of the display output path, one instance per TMDS channel.

Parameters:
- MIN_CTRL_RUN, 8: consecutive control tokens counted as a valid blanking run.
- SEARCH_WIN, 1024: valid words examined per alignment attempt before a bitslip is requested.
- SLIP_WAIT, 4: cycles ignored after a bitslip while the deserializer settles.
- LOCK_TIMEOUT, 1024: valid words allowed in LOCKED without a blanking run before lock is dropped.

Ports:
- clk_i  in  1  pixel clock.
- rst_i  in  1  synchronous reset, active-high.
- word_vld_i  in  1  tmds_word_i valid this cycle.
- tmds_word_i  in  10  channel word; bit 0 is the first bit on the wire.
- bitslip_o  out  1  one-cycle request to the deserializer to shift the word boundary by one bit.
- aligned_o  out  1  high while in LOCKED.
- out_vld_o  out  1  decoded outputs valid.
- de_o  out  1  data enable (1 = pixel data, 0 = control token).
- data_o  out  8  decoded pixel byte.
- ctrl_o  out  2  decoded control bits {C1,C0}.

Behaviour:
- Reset: all outputs 0; FSM = SEARCH; all counters 0. Reset applies mid-operation from any state, including SLIP_WAIT.
- Token detection on each valid word:
  - 0x354 → 00; 0x0AB → 01; 0x154 → 10; 0x2AB → 11.
  - Any other word is a data word.
- Data decode:
  - q = tmds_word_i; let b = q[9] ? ~q[7:0] : q[7:0].
  - d[0] = b[0].
  - For i = 1..7: d[i] = q[8] ? b[i]^b[i-1] : ~(b[i]^b[i-1]).
- Output pipeline, latency 1 cycle:
  - On a valid word: out_vld_o <= (state == LOCKED).
  - Token: de_o <= 0, ctrl_o <= token bits, data_o <= 0.
  - Data word: de_o <= 1, data_o <= d, ctrl_o holds its last value.
  - When word_vld_i = 0: out_vld_o <= 0; de_o, data_o and ctrl_o hold; no counter or FSM advances except the SLIP_WAIT counter.
- ctrl_run counter:
  - Counts consecutive valid tokens and saturates at MIN_CTRL_RUN.
  - Cleared by a valid data word.
  - "run_hit" = the valid word that makes ctrl_run reach MIN_CTRL_RUN.
- FSM:
  - SEARCH:
    - win_cnt counts valid words.
    - On run_hit → LOCKED; aligned_o = 1 the next cycle.
    - Otherwise, when win_cnt reaches SEARCH_WIN: bitslip_o = 1 for exactly one cycle → SLIP_WAIT.
    - If run_hit and window expiry occur on the same word, lock wins and no slip is issued.
  - SLIP_WAIT:
    - Counts SLIP_WAIT clock cycles, regardless of word_vld_i.
    - Then → SEARCH with win_cnt and ctrl_run cleared.
    - Input words are ignored for alignment; they are still decoded, with out_vld_o = 0.
  - LOCKED:
    - to_cnt counts valid words and is cleared at each run_hit.
    - After run_hit, ctrl_run must fall below MIN_CTRL_RUN (a data word) before another run_hit can occur.
    - When to_cnt reaches LOCK_TIMEOUT → SEARCH; aligned_o = 0 the next cycle; all counters cleared; no bitslip issued.
- bitslip_o is never asserted outside the SEARCH→SLIP_WAIT transition, and never on two consecutive cycles.
- Counter widths: $clog2(param+1); no wrap is possible because every counter compares against its limit.

Optional Feature:
- TMDS_DEC_STATS_EN defined:
  - adds slip_cnt_o [7:0], a saturating count of bitslip pulses;
  - adds relock_cnt_o [7:0], a saturating count of LOCKED→SEARCH transitions.
  - Both are 0 at reset.
- Not defined: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
1. Assert rst_i for 3 cycles with random input → all outputs 0; no bitslip pulse for SEARCH_WIN-1 valid words afterwards.
2. Aligned stream of 8×0x354, then 0x100, then 0x2FF → aligned_o rises 1 cycle after the 8th token.
   - Token output: de_o = 0, ctrl_o = 00, out_vld_o = 1 once locked.
   - 0x100 → de_o = 1, data_o = 0x00.
   - 0x2FF → data_o = 0xFE.
3. SEARCH_WIN=32, SLIP_WAIT=4; bench deserializer model starts 3 bits misaligned and rotates one bit per slip; stream of 800-word lines with 160 tokens each.
   - Exactly 3 single-cycle bitslip pulses, each spaced ≥ SLIP_WAIT+32 valid words apart.
   - Then aligned_o = 1, with no further slips.
4. Locked, then LOCK_TIMEOUT=64 continuous data words (0x100) → aligned_o falls after exactly 64 valid words; no bitslip on that transition.
5. Locked; word_vld_i toggled 1/0 during a token run of 8 → run_hit still occurs on the 8th valid token; outputs hold during invalid cycles with out_vld_o = 0.
6. rst_i asserted during SLIP_WAIT → SEARCH with counters 0.
   - With TMDS_DEC_STATS_EN: slip_cnt_o and relock_cnt_o = 0 after reset, and slip_cnt_o = 3 after scenario 3.

Source files
------------

// File: rtl/tmds_decoder.sv
// TMDS sink channel: bitslip-driven word alignment on control-token runs, 10b->8b data and token decode.
// Define TMDS_DEC_STATS_EN to add the saturating slip_cnt_o / relock_cnt_o statistics ports.
module tmds_decoder #(
    parameter int MIN_CTRL_RUN = 8,
    parameter int SEARCH_WIN   = 1024,
    parameter int SLIP_WAIT    = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       word_vld_i,
    input  logic [9:0] tmds_word_i,
    output logic       bitslip_o,
    output logic       aligned_o,
    output logic       out_vld_o,
    output logic       de_o,
    output logic [7:0] data_o,
    output logic [1:0] ctrl_o
`ifdef TMDS_DEC_STATS_EN
    ,
    output logic [7:0] slip_cnt_o,
    output logic [7:0] relock_cnt_o
`endif
);
    localparam int RUN_W  = $clog2(MIN_CTRL_RUN + 1);
    localparam int WIN_W  = $clog2(SEARCH_WIN + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MIN_CTRL_RUN);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(MIN_CTRL_RUN - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WIN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {ST_SEARCH, ST_SLIP_WAIT, ST_LOCKED} state_t;

    state_t            state, state_n;
    logic [RUN_W-1:0]  ctrl_run, ctrl_run_n;
    logic [WIN_W-1:0]  win_cnt, win_cnt_n;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
    logic [TO_W-1:0]   to_cnt, to_cnt_n;
    logic              bitslip_n;
    logic              is_tok;
    logic [1:0]        tok;
    logic [7:0]        b, d;
    logic              run_hit;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        is_tok = 1'b1;
        tok    = 2'b00;
        case (tmds_word_i)
            10'h354: tok = 2'b00;
            10'h0AB: tok = 2'b01;
            10'h154: tok = 2'b10;
            10'h2AB: tok = 2'b11;
            default: is_tok = 1'b0;
        endcase
    end

    always_comb begin
        b    = tmds_word_i[9] ? ~tmds_word_i[7:0] : tmds_word_i[7:0];
        d    = 8'h00;
        d[0] = b[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = tmds_word_i[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
        end
    end

    // Saturation of ctrl_run makes a hit fire once per run; a data word re-arms it.
    assign run_hit = word_vld_i && is_tok && (state != ST_SLIP_WAIT) && (ctrl_run == RUN_LAST);

    always_comb begin
        state_n    = state;
        ctrl_run_n = ctrl_run;
        win_cnt_n  = win_cnt;
        wait_cnt_n = wait_cnt;
        to_cnt_n   = to_cnt;
        bitslip_n  = 1'b0;

        if (word_vld_i && state != ST_SLIP_WAIT) begin
            if (!is_tok)
                ctrl_run_n = '0;
            else if (ctrl_run != RUN_MAX)
                ctrl_run_n = ctrl_run + 1'b1;
        end

        case (state)
            ST_SEARCH: begin
                if (word_vld_i) begin
                    if (run_hit) begin
                        state_n   = ST_LOCKED;
                        win_cnt_n = '0;
                        to_cnt_n  = '0;
                    end else if (win_cnt == WIN_LAST) begin
                        state_n    = ST_SLIP_WAIT;
                        bitslip_n  = 1'b1;
                        win_cnt_n  = '0;
                        wait_cnt_n = '0;
                    end else begin
                        win_cnt_n = win_cnt + 1'b1;
                    end
                end
            end
            ST_SLIP_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_n    = ST_SEARCH;
                    wait_cnt_n = '0;
                    win_cnt_n  = '0;
                    ctrl_run_n = '0;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (word_vld_i) begin
                    if (run_hit) begin
                        to_cnt_n = '0;
                    end else if (to_cnt == TO_LAST) begin
                        state_n    = ST_SEARCH;
                        to_cnt_n   = '0;
                        win_cnt_n  = '0;
                        ctrl_run_n = '0;
                    end else begin
                        to_cnt_n = to_cnt + 1'b1;
                    end
                end
            end
            default: state_n = ST_SEARCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_SEARCH;
            ctrl_run  <= '0;
            win_cnt   <= '0;
            wait_cnt  <= '0;
            to_cnt    <= '0;
            bitslip_o <= 1'b0;
        end else begin
            state     <= state_n;
            ctrl_run  <= ctrl_run_n;
            win_cnt   <= win_cnt_n;
            wait_cnt  <= wait_cnt_n;
            to_cnt    <= to_cnt_n;
            bitslip_o <= bitslip_n;
        end
    end

    assign aligned_o = (state == ST_LOCKED);

    // NOTE: decoded outputs are reset too, so a capture sees clean zeros rather than stale pixels.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_vld_o <= 1'b0;
            de_o      <= 1'b0;
            data_o    <= 8'h00;
            ctrl_o    <= 2'b00;
        end else if (word_vld_i) begin
            out_vld_o <= (state == ST_LOCKED);
            if (is_tok) begin
                de_o   <= 1'b0;
                ctrl_o <= tok;
                data_o <= 8'h00;
            end else begin
                de_o   <= 1'b1;
                data_o <= d;
            end
        end else begin
            out_vld_o <= 1'b0;
        end
    end

`ifdef TMDS_DEC_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slip_cnt_o   <= 8'h00;
            relock_cnt_o <= 8'h00;
        end else begin
            if (bitslip_o && slip_cnt_o != 8'hFF)
                slip_cnt_o <= slip_cnt_o + 8'h01;
            if (state == ST_LOCKED && state_n == ST_SEARCH && relock_cnt_o != 8'hFF)
                relock_cnt_o <= relock_cnt_o + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: decode vector table plus alignment, timeout and reset sequences.
// Build with TMDS_DEC_STATS_EN defined to also check the statistics counters.
module tb_tmds_decoder;
    localparam int RUN   = 8;
    localparam int WIN   = 32;
    localparam int WAITC = 4;
    localparam int TMO   = 64;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       word_vld_i = 1'b0;
    logic [9:0] tmds_word_i = 10'h000;
    logic       bitslip_o, aligned_o, out_vld_o, de_o;
    logic [7:0] data_o;
    logic [1:0] ctrl_o;
`ifdef TMDS_DEC_STATS_EN
    logic [7:0] slip_cnt_o, relock_cnt_o;
`endif

    tmds_decoder #(
        .MIN_CTRL_RUN(RUN),
        .SEARCH_WIN  (WIN),
        .SLIP_WAIT   (WAITC),
        .LOCK_TIMEOUT(TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .word_vld_i  (word_vld_i),
        .tmds_word_i (tmds_word_i),
        .bitslip_o   (bitslip_o),
        .aligned_o   (aligned_o),
        .out_vld_o   (out_vld_o),
        .de_o        (de_o),
        .data_o      (data_o),
        .ctrl_o      (ctrl_o)
`ifdef TMDS_DEC_STATS_EN
        ,
        .slip_cnt_o  (slip_cnt_o),
        .relock_cnt_o(relock_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [9:0] word;
        logic       o_vld;
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       aligned;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   slip_total = 0;
    logic prev_slip = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse monitor: counts bitslip pulses and rejects back-to-back assertions.
    always @(negedge clk) begin
        if (bitslip_o) begin
            slip_total <= slip_total + 1;
            check("slip_single_cycle", 32'(prev_slip), 32'd0);
        end
        prev_slip <= bitslip_o;
    end

    function automatic logic [31:0] outs();
        return {18'b0, out_vld_o, de_o, data_o, ctrl_o, aligned_o, bitslip_o};
    endfunction

    function automatic vec_t mk(input logic vld, input logic [9:0] word, input logic o_vld,
                                input logic de, input logic [7:0] data, input logic [1:0] ctrl,
                                input logic aligned);
        vec_t v;
        v.vld = vld; v.word = word; v.o_vld = o_vld; v.de = de;
        v.data = data; v.ctrl = ctrl; v.aligned = aligned;
        return v;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        w = 10'($urandom_range(0, 1023));
        if (w == 10'h354 || w == 10'h0AB || w == 10'h154 || w == 10'h2AB) w = 10'h100;
        return w;
    endfunction

    // Transmitted line: 160 blanking tokens (0x354) then 640 data words (0x100); bit 0 first.
    function automatic logic line_bit(input int p);
        logic [9:0] sym;
        sym = (((p / 10) % 800) < 160) ? 10'h354 : 10'h100;
        return sym[p % 10];
    endfunction

    function automatic logic [9:0] des_word(input int n, input int off);
        logic [9:0] w;
        for (int j = 0; j < 10; j++) w[j] = line_bit(10 * n + off + j);
        return w;
    endfunction

    task automatic apply(input logic vld, input logic [9:0] w);
        @(negedge clk);
        word_vld_i  = vld;
        tmds_word_i = w;
        @(posedge clk);
        #1;
    endtask

    // Holds rst_i for 'cycles' edges with random inputs; returns at a negedge with reset released.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_i = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (i > 0) @(negedge clk);
            word_vld_i  = 1'($urandom_range(0, 1));
            tmds_word_i = 10'($urandom_range(0, 1023));
        end
        @(negedge clk);
        rst_i      = 1'b0;
        word_vld_i = 1'b0;
    endtask

    task automatic search_window(input string tag);
        for (int k = 1; k <= WIN; k++) begin
            apply(1'b1, rand_data());
            if (k < WIN) check({tag, "_no_early_slip"}, 32'(bitslip_o), 32'd0);
            else         check({tag, "_slip_at_window"}, 32'(bitslip_o), 32'd1);
        end
        apply(1'b1, rand_data());
        check({tag, "_slip_one_cycle"}, 32'(bitslip_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        int   s0;
        int   off;
        int   lock_at;
        int   slip_at[$];

        // Reset with random input, then one full search window.
        do_reset(3);
        check("reset_outputs", outs(), 32'd0);
`ifdef TMDS_DEC_STATS_EN
        check("reset_slip_cnt", 32'(slip_cnt_o), 32'd0);
        check("reset_relock_cnt", 32'(relock_cnt_o), 32'd0);
`endif
        search_window("t1");

        // Now in SLIP_WAIT: reset must return to SEARCH with a fresh window.
        do_reset(1);
        check("slipwait_reset_outputs", outs(), 32'd0);
        search_window("t6");

        // Decode table: lock on 8 tokens, data/token decode, hold on invalid, toggled token run.
        for (int i = 0; i < RUN; i++) tbl.push_back(mk(1, 10'h354, 0, 0, 8'h00, 2'b00, i == RUN - 1));
        tbl.push_back(mk(1, 10'h100, 1, 1, 8'h00, 2'b00, 1));
        tbl.push_back(mk(1, 10'h2FF, 1, 1, 8'hFE, 2'b00, 1));
        tbl.push_back(mk(1, 10'h2AB, 1, 0, 8'h00, 2'b11, 1));
        tbl.push_back(mk(1, 10'h0AB, 1, 0, 8'h00, 2'b01, 1));
        tbl.push_back(mk(1, 10'h154, 1, 0, 8'h00, 2'b10, 1));
        tbl.push_back(mk(1, 10'h1FF, 1, 1, 8'h01, 2'b10, 1));
        tbl.push_back(mk(0, 10'h354, 0, 1, 8'h01, 2'b10, 1));
        tbl.push_back(mk(1, 10'h0FF, 1, 1, 8'hFF, 2'b10, 1));
        tbl.push_back(mk(1, 10'h133, 1, 1, 8'h55, 2'b10, 1));
        tbl.push_back(mk(1, 10'h2AA, 1, 1, 8'h01, 2'b10, 1));
        for (int t = 0; t < RUN; t++) begin
            tbl.push_back(mk(1, 10'h354, 1, 0, 8'h00, 2'b00, 1));
            if (t < RUN - 1) tbl.push_back(mk(0, 10'h2FF, 0, 0, 8'h00, 2'b00, 1));
        end

        do_reset(2);
        foreach (tbl[i]) begin
            apply(tbl[i].vld, tbl[i].word);
            check($sformatf("vec%0d", i), outs(),
                  {18'b0, tbl[i].o_vld, tbl[i].de, tbl[i].data, tbl[i].ctrl, tbl[i].aligned, 1'b0});
        end

        // The last token above was a fresh run_hit, so lock must last exactly TMO more data words.
        s0 = slip_total;
        for (int k = 1; k <= TMO; k++) begin
            apply(1'b1, 10'h100);
            check($sformatf("timeout_aligned_w%0d", k), 32'(aligned_o), 32'(k < TMO));
        end
        check("timeout_last_out_vld", 32'(out_vld_o), 32'd1);
        apply(1'b1, 10'h100);
        check("after_timeout_outs", outs(), {18'b0, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0});
        check("timeout_no_slip", 32'(slip_total), 32'(s0));
`ifdef TMDS_DEC_STATS_EN
        check("relock_cnt_after_timeout", 32'(relock_cnt_o), 32'd1);
`endif

        // Misaligned deserializer model: offset 7 reaches word alignment after 3 slips.
        do_reset(2);
        off     = 7;
        lock_at = -1;
        for (int n = 0; n < 170; n++) begin
            @(negedge clk);
            if (bitslip_o) begin
                off = (off + 1) % 10;
                slip_at.push_back(n);
            end
            if (aligned_o && lock_at < 0) lock_at = n;
            word_vld_i  = 1'b1;
            tmds_word_i = des_word(n, off);
        end
        @(posedge clk);
        #1;
        check("t3_slip_count", 32'(slip_at.size()), 32'd3);
        if (slip_at.size() > 0) check("t3_first_slip_word", 32'(slip_at[0]), 32'(WIN));
        for (int i = 1; i < slip_at.size(); i++)
            check($sformatf("t3_spacing%0d", i), 32'(slip_at[i] - slip_at[i-1] >= WAITC + WIN), 32'd1);
        check("t3_model_offset", 32'(off), 32'd0);
        check("t3_lock_word", 32'(lock_at), 32'd116);
        check("t3_aligned", 32'(aligned_o), 32'd1);
`ifdef TMDS_DEC_STATS_EN
        check("t3_slip_cnt", 32'(slip_cnt_o), 32'd3);
`endif

        @(negedge clk);
        word_vld_i = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
